// File: rtl/rx_router_pkg.sv
// rx_router_pkg: shared stream type, parser state enum and default destination codes
package rx_router_pkg;
  typedef struct packed {
    logic [7:0] Data;
    logic       Valid;
    logic       SoP;
    logic       EoP;
  } UART_PACKET;
  typedef enum logic [1:0] {IDLE, FORWARD, DROP} RX_ROUTER_STATE;
  localparam logic [7:0] DEST1_DEFAULT = 8'h01;
  localparam logic [7:0] DEST2_DEFAULT = 8'h02;
endpackage

// File: rtl/rx_router_fifo.sv
// rx_fifo: 10-bit first-word-fall-through FIFO; push_i/data_i in, pop_i/data_o out, full_o/almost_full_o/empty_o flags
module rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [9:0] data_i,
  input  logic       pop_i,
  output logic [9:0] data_o,
  output logic       full_o,
  output logic       almost_full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [9:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q, cnt;
  assign cnt = wr_q - rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign almost_full_o = cnt == (AW+1)'(DEPTH - 1);
  assign data_o = empty_o ? 10'h0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(push_i & !full_o);
      rd_q <= rd_q + (AW+1)'(pop_i & !empty_o);
    end
  always_ff @(posedge clk_i)
    if (push_i & !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/rx_router.sv
// rx_router: routes UART_PACKET stream to two FIFO-buffered outputs by SoP header; ipRxStream in, opRxStream1/2 with ipRxReady1/2 out, opDropCount
import rx_router_pkg::*;
module rx_router #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] DEST1 = DEST1_DEFAULT,
  parameter logic [7:0] DEST2 = DEST2_DEFAULT
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  UART_PACKET ipRxStream,
  output UART_PACKET opRxStream1,
  input  logic       ipRxReady1,
  output UART_PACKET opRxStream2,
  input  logic       ipRxReady2,
  output logic [7:0] opDropCount
);
  RX_ROUTER_STATE state_q, state_d;
  logic dest2_q, dest2_d;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_sum;
  logic [1:0] inc;
  logic sop_in, hit1, hit2, routed, sel2, full_sel, af_sel, push, trunc;
  logic [9:0] wdata, head1, head2;
  logic full1, full2, af1, af2, empty1, empty2;
  assign sop_in = ipRxStream.Valid & ipRxStream.SoP;
  assign hit1 = ipRxStream.Data == DEST1;
  assign hit2 = ipRxStream.Data == DEST2 & !hit1;
  assign routed = ipRxStream.Valid & (ipRxStream.SoP ? (hit1 | hit2) : state_q == FORWARD);
  assign sel2 = ipRxStream.SoP ? hit2 : dest2_q;
  assign full_sel = sel2 ? full2 : full1;
  assign af_sel = sel2 ? af2 : af1;
  assign push = routed & !full_sel;
  assign trunc = push & af_sel & !ipRxStream.EoP;
  assign wdata = {ipRxStream.SoP, ipRxStream.EoP | trunc, ipRxStream.Data};
  assign inc = 2'(sop_in & state_q == FORWARD) + 2'(sop_in & !hit1 & !hit2) + 2'(routed & full_sel) + 2'(trunc);
  assign cnt_sum = {1'b0, cnt_q} + {7'd0, inc};
  always_comb begin
    state_d = (sop_in & !hit1 & !hit2) ? DROP :
              routed ? ((full_sel | trunc) ? DROP : (ipRxStream.EoP ? IDLE : FORWARD)) :
              (ipRxStream.Valid & ipRxStream.EoP & state_q == DROP) ? IDLE : state_q;
    dest2_d = (sop_in & (hit1 | hit2)) ? hit2 : dest2_q;
    cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end
  always_ff @(posedge ipClk or posedge ipReset)
    if (ipReset) begin
      state_q <= IDLE;
      dest2_q <= 1'b0;
      cnt_q <= 8'h0;
    end else begin
      state_q <= state_d;
      dest2_q <= dest2_d;
      cnt_q <= cnt_d;
    end
  rx_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk_i(ipClk), .rst_i(ipReset), .push_i(push & !sel2), .data_i(wdata),
    .pop_i(ipRxReady1 & !empty1), .data_o(head1), .full_o(full1),
    .almost_full_o(af1), .empty_o(empty1)
  );
  rx_fifo #(.DEPTH(DEPTH)) u_fifo2 (
    .clk_i(ipClk), .rst_i(ipReset), .push_i(push & sel2), .data_i(wdata),
    .pop_i(ipRxReady2 & !empty2), .data_o(head2), .full_o(full2),
    .almost_full_o(af2), .empty_o(empty2)
  );
  assign opRxStream1 = '{Data: head1[7:0], Valid: !empty1, SoP: head1[9], EoP: head1[8]};
  assign opRxStream2 = '{Data: head2[7:0], Valid: !empty2, SoP: head2[9], EoP: head2[8]};
  assign opDropCount = cnt_q;
endmodule

// File: doc/rx_router.md
# rx_router

Receive-side packet demultiplexer for the Comms path. It sits between the UART receiver and the two packet consumers, and is the inverse of the two-input TX arbiter. It accepts one UART_PACKET byte stream with no back-pressure and reads the destination from each packet's SoP byte. Whole packets are buffered into one of two per-destination FIFOs and presented on ready/valid output streams; unroutable or overflowing packets are discarded with framing preserved.

## Interface
- DEPTH, 16: entries per output FIFO; power of two, ≥ 4
- DEST1, 8'h01: SoP Data value routed to output 1
- DEST2, 8'h02: SoP Data value routed to output 2
- ipClk  input  1  system clock; all logic rising-edge
- ipReset  input  1  asynchronous, active-high reset
- ipRxStream  input  UART_PACKET  byte stream from UART RX (Data[7:0], Valid, SoP, EoP); no ready, a Valid byte must be taken or dropped in its cycle
- opRxStream1  output  UART_PACKET  stream to consumer 1
- ipRxReady1  input  1  consumer 1 accepts
- opRxStream2  output  UART_PACKET  stream to consumer 2
- ipRxReady2  input  1  consumer 2 accepts
- opDropCount  output  8  saturating count of packets discarded or truncated

## Operation
- Parser FSM states: IDLE, FORWARD, DROP; register dest (1 or 2).
- IDLE, Valid & SoP: Data==DEST1 → dest=1; Data==DEST2 → dest=2; else → DROP with opDropCount+1. Routed SoP byte is written to FIFO[dest] (the header byte is forwarded). If the byte also carries EoP, stay in IDLE; otherwise → FORWARD.
- IDLE, Valid & !SoP: discard the byte; no count.
- FORWARD, Valid & !SoP: write to FIFO[dest]; EoP → IDLE.
- FORWARD, Valid & SoP (new packet before EoP): opDropCount+1; handle the byte exactly as in IDLE. Consumers treat SoP as a packet boundary.
- DROP: discard bytes; EoP → IDLE; SoP → handle as in IDLE.
- Overflow:
  - FIFO[dest] occupancy DEPTH-1 and incoming byte not EoP → write it with EoP forced to 1, opDropCount+1, → DROP.
  - FIFO full → discard the byte, opDropCount+1, → DROP.
  - Consumers therefore always see SoP…EoP-framed packets.
- FIFO entry: {SoP, EoP, Data} = 10 bits. Output presents the head entry; Valid = !empty. Pop when Valid & ipRxReadyN.
- opDropCount saturates at 8'hFF.
- Both outputs are independent; a stalled consumer never blocks the other destination.

## Timing
- Reset (asynchronous assert): opRxStream1/2 all fields 0, FIFOs empty, opDropCount 0, FSM IDLE, dest 1. No output changes during reset.
- Latency: byte Valid at cycle t → written at edge t → opRxStreamN.Valid high in cycle t+1.
- Throughput: 1 byte/cycle in; 1 byte/cycle per output.
- Full/space decisions use pre-pop occupancy. A pop in the same cycle does not free space for that cycle's write. Simultaneous push and pop on a non-full FIFO leaves occupancy unchanged.
- Pointers are log2(DEPTH)-bit with an extra wrap bit; full = pointers equal except MSB.
- Outputs stay stable while Valid & !ipRxReadyN.
- Reset mid-packet: buffered data is lost; after release the FSM resynchronises on the next SoP.

## Structure
- Structures package: UART_PACKET (existing), new RX_ROUTER_STATE enum {IDLE, FORWARD, DROP}, default DEST1/DEST2 constants.
- One sub-module: rx_fifo (DEPTH parameter, 10-bit, registered pointers, push/pop/full/almost_full/empty, first-word presented on output). Instantiated twice.
- Top level: parser FSM, drop counter, two rx_fifo instances.

## Test plan
- Routing: packet {01 SoP, AA, BB EoP}, then {02 SoP, CC EoP}, both readies high → out1 gets 01,AA,BB (SoP on 01, EoP on BB) starting cycle t+1; out2 gets 02,CC; opDropCount 0.
- Unroutable: packet {07 SoP, 11, 22 EoP} → nothing on either output; opDropCount=1; a following 01 packet routes normally.
- Overflow: ipRxReady1=0, DEPTH=16, 20-byte packet to DEST1 → FIFO holds 16 entries, 16th has EoP forced; remaining bytes dropped; opDropCount=1; releasing ready drains exactly 16 bytes.
- Independence/back-pressure: ipRxReady2 toggling 1-of-3 cycles while streaming to DEST1 at full rate → out1 unaffected; out2 bytes delivered in order, none lost or duplicated.
- Mid-packet SoP: {01 SoP, AA} then {02 SoP, CC EoP} → out1 gets 01,AA with no EoP; out2 gets full packet; opDropCount=1.
- Async reset asserted mid-packet with both FIFOs non-empty → all Valid 0 immediately, counters 0; post-release a 01 packet routes correctly.
